// File: rtl/run_seq_pkg.sv
// Shared definitions for the run sequencer: state encoding and the
// per-core reset-release point.
package run_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Value of the reset-phase counter on whose edge core_idx is released.
    function automatic int release_count(input int core_idx,
                                         input int reset_cycles,
                                         input int stagger);
        return reset_cycles - 1 + core_idx * stagger;
    endfunction

endpackage

// File: rtl/run_seq_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Count while enabled, stick at all-ones; clear beats enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= {W{1'b0}};
        end else if (clr) begin
            r_q <= {W{1'b0}};
        end else if (en && (r_q != {W{1'b1}})) begin
            r_q <= r_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/run_sequencer.sv
// Run controller: holds cores in reset (optionally staggered), supervises
// the run for halts or budget exhaustion, and reports completion.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int NUM_CORES    = 1,
    parameter int RESET_CYCLES = 5,
    parameter int STAGGER      = 0,
    parameter int MAX_CYCLES   = 50,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] halt,
    output logic [NUM_CORES-1:0] core_rst,
    output logic                 running,
    output logic                 done,
    output logic                 timeout,
    output logic [NUM_CORES-1:0] halted_mask,
    output logic [CNT_W-1:0]     cycle_count
);

    // The last core to be released has the largest release count.
    localparam int LAST_REL = release_count(NUM_CORES - 1, RESET_CYCLES, STAGGER);
    localparam int RST_W    = $clog2(LAST_REL + 2);
    localparam logic [RST_W-1:0]     LAST_REL_V = RST_W'(LAST_REL);
    localparam logic [CNT_W-1:0]     MAX_M1     = CNT_W'(MAX_CYCLES - 1);
    localparam logic [NUM_CORES-1:0] ALL_ONES   = {NUM_CORES{1'b1}};
    localparam logic [NUM_CORES-1:0] ALL_ZEROS  = {NUM_CORES{1'b0}};

    state_t                r_state;
    state_t                w_state_next;
    logic [NUM_CORES-1:0]  r_core_rst;
    logic [NUM_CORES-1:0]  w_core_rst_next;
    logic [NUM_CORES-1:0]  r_halted_mask;
    logic [NUM_CORES-1:0]  w_mask_next;
    logic                  r_running;
    logic                  r_done;
    logic                  r_timeout;
    logic                  w_timeout_next;
    logic                  w_start_seq;
    logic [NUM_CORES-1:0]  w_release;
    logic [RST_W-1:0]      w_rst_cnt;
    logic [CNT_W-1:0]      w_cycle_count;

    // start only matters when a new sequence may begin.
    assign w_start_seq = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    sat_counter #(.W(RST_W)) u_rst_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_start_seq),
        .en  (r_state == ST_RESET),
        .q   (w_rst_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_start_seq),
        .en  (r_state == ST_RUN),
        .q   (w_cycle_count)
    );

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_release
        assign w_release[gi] =
            (w_rst_cnt == RST_W'(release_count(gi, RESET_CYCLES, STAGGER)));
    end

    // Next-state, per-core reset release, halt collection and timeout flag.
    always_comb begin
        w_state_next    = r_state;
        w_core_rst_next = r_core_rst;
        w_mask_next     = r_halted_mask;
        w_timeout_next  = r_timeout;
        case (r_state)
            ST_IDLE: begin
                w_core_rst_next = ALL_ONES;
                w_mask_next     = ALL_ZEROS;
                w_timeout_next  = 1'b0;
                if (start) begin
                    w_state_next = ST_RESET;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RESET: begin
                // A released core is never re-asserted: only clear bits.
                w_core_rst_next = r_core_rst & ~w_release;
                if (w_rst_cnt == LAST_REL_V) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_RESET;
                end
            end
            ST_RUN: begin
                w_mask_next = r_halted_mask | (halt & ~r_core_rst);
                // A final halt outranks budget exhaustion in the same cycle.
                if (w_mask_next == ALL_ONES) begin
                    w_state_next   = ST_DONE;
                    w_timeout_next = 1'b0;
                end else if ((MAX_CYCLES != 0) && (w_cycle_count == MAX_M1)) begin
                    w_state_next   = ST_DONE;
                    w_timeout_next = 1'b1;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_next    = ST_RESET;
                    w_core_rst_next = ALL_ONES;
                    w_mask_next     = ALL_ZEROS;
                    w_timeout_next  = 1'b0;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_core_rst_next = ALL_ONES;
                w_mask_next     = ALL_ZEROS;
                w_timeout_next  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; status flags follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_core_rst    <= ALL_ONES;
            r_halted_mask <= ALL_ZEROS;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_core_rst    <= w_core_rst_next;
            r_halted_mask <= w_mask_next;
            r_running     <= (w_state_next == ST_RUN);
            r_done        <= (w_state_next == ST_DONE);
            r_timeout     <= w_timeout_next;
        end
    end

    assign core_rst    = r_core_rst;
    assign running     = r_running;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign halted_mask = r_halted_mask;
    assign cycle_count = w_cycle_count;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: one table-driven two-core instance plus
// hand sequences for defaults, staggered release and counter saturation.
module tb_run_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: defaults (1 core, 5 reset cycles, budget 50)
    logic        a_rst = 1'b1, a_start = 1'b0;
    logic [0:0]  a_halt = 1'b0, a_core_rst, a_mask;
    logic        a_running, a_done, a_timeout;
    logic [31:0] a_cnt;
    run_sequencer u_a (
        .clk(clk), .rst(a_rst), .start(a_start), .halt(a_halt),
        .core_rst(a_core_rst), .running(a_running), .done(a_done),
        .timeout(a_timeout), .halted_mask(a_mask), .cycle_count(a_cnt));

    // Instance B: 2 cores, table driven
    logic        b_rst = 1'b1, b_start = 1'b0;
    logic [1:0]  b_halt = 2'b00, b_core_rst, b_mask;
    logic        b_running, b_done, b_timeout;
    logic [31:0] b_cnt;
    run_sequencer #(.NUM_CORES(2)) u_b (
        .clk(clk), .rst(b_rst), .start(b_start), .halt(b_halt),
        .core_rst(b_core_rst), .running(b_running), .done(b_done),
        .timeout(b_timeout), .halted_mask(b_mask), .cycle_count(b_cnt));

    // Instance C: 3 cores, 4 reset cycles, stagger 2
    logic        c_rst = 1'b1, c_start = 1'b0;
    logic [2:0]  c_halt = 3'b000, c_core_rst, c_mask;
    logic        c_running, c_done, c_timeout;
    logic [31:0] c_cnt;
    run_sequencer #(.NUM_CORES(3), .RESET_CYCLES(4), .STAGGER(2)) u_c (
        .clk(clk), .rst(c_rst), .start(c_start), .halt(c_halt),
        .core_rst(c_core_rst), .running(c_running), .done(c_done),
        .timeout(c_timeout), .halted_mask(c_mask), .cycle_count(c_cnt));

    // Instance D: 4-bit counter, timeout disabled
    logic        d_rst = 1'b1, d_start = 1'b0;
    logic [0:0]  d_halt = 1'b0, d_core_rst, d_mask;
    logic        d_running, d_done, d_timeout;
    logic [3:0]  d_cnt;
    run_sequencer #(.MAX_CYCLES(0), .CNT_W(4)) u_d (
        .clk(clk), .rst(d_rst), .start(d_start), .halt(d_halt),
        .core_rst(d_core_rst), .running(d_running), .done(d_done),
        .timeout(d_timeout), .halted_mask(d_mask), .cycle_count(d_cnt));

    typedef struct {
        logic        rst;
        logic        start;
        logic [1:0]  halt;
        int          ncyc;
        logic [1:0]  cr;
        logic        run;
        logic        dn;
        logic        to;
        logic [1:0]  mask;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] e_cr;

        //          rst   start halt   n   cr     run   done  to    mask   cnt
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 1,  2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0};
        vecs[1]  = '{1'b0, 1'b1, 2'b00, 1,  2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0};
        vecs[2]  = '{1'b0, 1'b0, 2'b00, 5,  2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0};
        vecs[3]  = '{1'b0, 1'b0, 2'b00, 10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 32'd10};
        vecs[4]  = '{1'b0, 1'b0, 2'b01, 1,  2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 32'd11};
        vecs[5]  = '{1'b0, 1'b0, 2'b00, 9,  2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 32'd20};
        vecs[6]  = '{1'b0, 1'b0, 2'b10, 1,  2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 32'd21};
        vecs[7]  = '{1'b0, 1'b0, 2'b00, 3,  2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 32'd21};
        vecs[8]  = '{1'b0, 1'b1, 2'b00, 1,  2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0};
        vecs[9]  = '{1'b0, 1'b1, 2'b11, 1,  2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0};
        vecs[10] = '{1'b0, 1'b0, 2'b00, 4,  2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0};
        vecs[11] = '{1'b0, 1'b0, 2'b00, 10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 32'd10};
        vecs[12] = '{1'b0, 1'b1, 2'b00, 1,  2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 32'd11};
        vecs[13] = '{1'b0, 1'b0, 2'b01, 4,  2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 32'd15};
        vecs[14] = '{1'b1, 1'b0, 2'b00, 1,  2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0};
        vecs[15] = '{1'b0, 1'b0, 2'b00, 3,  2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0};
        vecs[16] = '{1'b0, 1'b1, 2'b00, 1,  2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0};
        vecs[17] = '{1'b0, 1'b0, 2'b00, 5,  2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0};
        vecs[18] = '{1'b0, 1'b0, 2'b01, 1,  2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 32'd1};
        vecs[19] = '{1'b0, 1'b0, 2'b00, 48, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 32'd49};
        vecs[20] = '{1'b0, 1'b0, 2'b10, 1,  2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 32'd50};
        vecs[21] = '{1'b0, 1'b1, 2'b00, 1,  2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0};
        vecs[22] = '{1'b0, 1'b0, 2'b00, 5,  2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0};
        vecs[23] = '{1'b0, 1'b0, 2'b01, 1,  2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 32'd1};
        vecs[24] = '{1'b0, 1'b0, 2'b00, 49, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 32'd50};

        // Reset state of instance A
        step(1);
        chk("A rst core_rst", a_core_rst, 1);
        chk("A rst running", a_running, 0);
        chk("A rst done", a_done, 0);
        chk("A rst timeout", a_timeout, 0);
        chk("A rst mask", a_mask, 0);
        chk("A rst count", a_cnt, 0);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0; d_rst = 1'b0;
        step(1);

        // Instance A: 5 reset cycles, then run to budget timeout
        a_start = 1'b1;
        step(1);
        a_start = 1'b0;
        chk("A start core_rst", a_core_rst, 1);
        chk("A start running", a_running, 0);
        step(4);
        chk("A hold core_rst", a_core_rst, 1);
        chk("A hold running", a_running, 0);
        step(1);
        chk("A release core_rst", a_core_rst, 0);
        chk("A release running", a_running, 1);
        chk("A release count", a_cnt, 0);
        step(49);
        chk("A pre-budget count", a_cnt, 49);
        chk("A pre-budget done", a_done, 0);
        step(1);
        chk("A budget done", a_done, 1);
        chk("A budget timeout", a_timeout, 1);
        chk("A budget count", a_cnt, 50);
        chk("A budget running", a_running, 0);
        step(5);
        chk("A frozen count", a_cnt, 50);
        chk("A frozen done", a_done, 1);
        chk("A frozen core_rst", a_core_rst, 0);

        // Instance C: staggered release after 4, 6, 8 reset cycles
        c_start = 1'b1;
        step(1);
        c_start = 1'b0;
        chk("C start core_rst", c_core_rst, 3'b111);
        for (int k = 1; k <= 9; k++) begin
            step(1);
            for (int i = 0; i < 3; i++) e_cr[i] = (k < 4 + 2 * i);
            chk($sformatf("C k%0d core_rst", k), c_core_rst, e_cr);
            chk($sformatf("C k%0d running", k), c_running, (k >= 8) ? 1 : 0);
        end

        // Instance D: 4-bit count saturates, no timeout
        d_start = 1'b1;
        step(1);
        d_start = 1'b0;
        step(5);
        chk("D run entry", d_running, 1);
        step(15);
        chk("D count 15", d_cnt, 15);
        step(10);
        chk("D saturated", d_cnt, 15);
        chk("D no done", d_done, 0);
        chk("D still running", d_running, 1);

        // Instance B: table of halt, restart, mid-run reset and tie cases
        for (int k = 0; k < 25; k++) begin
            b_rst   = vecs[k].rst;
            b_start = vecs[k].start;
            b_halt  = vecs[k].halt;
            step(vecs[k].ncyc);
            b_rst   = 1'b0;
            b_start = 1'b0;
            b_halt  = 2'b00;
            chk($sformatf("B v%0d core_rst", k), b_core_rst, vecs[k].cr);
            chk($sformatf("B v%0d running", k), b_running, vecs[k].run);
            chk($sformatf("B v%0d done", k), b_done, vecs[k].dn);
            chk($sformatf("B v%0d timeout", k), b_timeout, vecs[k].to);
            chk($sformatf("B v%0d mask", k), b_mask, vecs[k].mask);
            chk($sformatf("B v%0d count", k), b_cnt, vecs[k].cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
